// File: rtl/mmio_memory_bus_pkg.sv
// mmio_memory_bus_pkg: MMIO register offsets and address-decode targets for mmio_memory_bus.
package mmio_memory_bus_pkg;
    localparam logic [29:0] MMIO_OFF_HEX  = 30'd0;
    localparam logic [29:0] MMIO_OFF_LEDR = 30'd1;
    localparam logic [29:0] MMIO_OFF_KEY  = 30'd2;
    localparam logic [29:0] MMIO_OFF_SW   = 30'd3;
    localparam logic [29:0] MMIO_OFF_KEYP = 30'd4;
    localparam logic [29:0] MMIO_OFF_TIME = 30'd5;

    typedef enum logic [2:0] {
        DEC_RAM,
        DEC_HEX,
        DEC_LEDR,
        DEC_KEY,
        DEC_SW,
        DEC_KEYP,
        DEC_TIME,
        DEC_NONE
    } dec_e;
endpackage

// File: rtl/mmio_input_sync.sv
// mmio_input_sync: 2-flop synchroniser for asynchronous board inputs plus a rising-edge pulse.
module mmio_input_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);
    logic [WIDTH-1:0] s1, s2, s3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;
endmodule

// File: rtl/mmio_memory_bus.sv
// mmio_memory_bus: word-addressed data RAM plus HEX/LEDR/KEY/SW/KEYP MMIO behind a valid/ready port.
// Define MMIO_TIMER_EN to add a free-running 32-bit cycle counter at MMIO offset 5.
module mmio_memory_bus
    import mmio_memory_bus_pkg::*;
#(
    parameter string       MEM_INIT_FILE  = "",
    parameter int          ADDR_BIT_WIDTH = 11,
    parameter int          DATA_BIT_WIDTH = 32,
    parameter logic [29:0] MMIO_BASE      = 30'h3FFFFFF0,
    parameter int          HEX_WIDTH      = 16,
    parameter int          SW_WIDTH       = 10,
    parameter int          KEY_WIDTH      = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [29:0]                 req_addr,
    input  logic [DATA_BIT_WIDTH-1:0]   req_wdata,
    input  logic [DATA_BIT_WIDTH/8-1:0] req_be,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_BIT_WIDTH-1:0]   rsp_rdata,
    output logic                        rsp_err,
    input  logic [KEY_WIDTH-1:0]        key_in,
    input  logic [SW_WIDTH-1:0]         sw_in,
    output logic [HEX_WIDTH-1:0]        hex_out,
    output logic [SW_WIDTH-1:0]         ledr_out
);
    localparam int DW = DATA_BIT_WIDTH;

    (* ram_init_file = MEM_INIT_FILE *) logic [DW-1:0] mem [2**ADDR_BIT_WIDTH];

    logic [KEY_WIDTH-1:0] key_lvl, key_rise, keyp, keyp_clr;
    logic [SW_WIDTH-1:0]  sw_lvl, sw_rise_unused;
    logic [29:0]          off;
    logic                 accept, wr;
    dec_e                 dec;
    logic [DW-1:0]        rd;
`ifdef MMIO_TIMER_EN
    logic [31:0]          timer;
`endif

    mmio_input_sync #(.WIDTH(KEY_WIDTH)) u_key_sync (.clk(clk), .reset(reset), .d(key_in), .level(key_lvl), .rise(key_rise));
    mmio_input_sync #(.WIDTH(SW_WIDTH))  u_sw_sync  (.clk(clk), .reset(reset), .d(sw_in),  .level(sw_lvl),  .rise(sw_rise_unused));

    assign req_ready = ~rsp_valid | rsp_ready;
    assign accept    = req_valid & req_ready;
    assign wr        = accept & req_write;
    assign off       = req_addr - MMIO_BASE;

    always_comb begin
        dec = (req_addr >> ADDR_BIT_WIDTH) == 30'd0 ? DEC_RAM  :
              off == MMIO_OFF_HEX                    ? DEC_HEX  :
              off == MMIO_OFF_LEDR                   ? DEC_LEDR :
              off == MMIO_OFF_KEY                    ? DEC_KEY  :
              off == MMIO_OFF_SW                     ? DEC_SW   :
              off == MMIO_OFF_KEYP                   ? DEC_KEYP :
`ifdef MMIO_TIMER_EN
              off == MMIO_OFF_TIME                   ? DEC_TIME :
`endif
                                                       DEC_NONE;
        rd = dec == DEC_RAM  ? mem[req_addr[ADDR_BIT_WIDTH-1:0]] :
             dec == DEC_HEX  ? DW'(hex_out)  :
             dec == DEC_LEDR ? DW'(ledr_out) :
             dec == DEC_KEY  ? DW'(key_lvl)  :
             dec == DEC_SW   ? DW'(sw_lvl)   :
`ifdef MMIO_TIMER_EN
             dec == DEC_TIME ? DW'(timer)    :
`endif
             dec == DEC_KEYP ? DW'(keyp)     : '0;
        keyp_clr = (wr && dec == DEC_KEYP) ? req_wdata[KEY_WIDTH-1:0] : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            hex_out   <= '0;
            ledr_out  <= '0;
            keyp      <= '0;
        end else begin
            if (accept) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= req_write ? '0 : rd;
                rsp_err   <= dec == DEC_NONE;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            if (wr && dec == DEC_HEX)
                hex_out <= req_wdata[HEX_WIDTH-1:0];
            if (wr && dec == DEC_LEDR)
                ledr_out <= req_wdata[SW_WIDTH-1:0];
            // a new edge beats a simultaneous write-1-to-clear
            keyp <= (keyp & ~keyp_clr) | key_rise;
        end
    end

    always_ff @(posedge clk) begin
        if (wr && dec == DEC_RAM)
            for (int b = 0; b < DW/8; b++)
                if (req_be[b])
                    mem[req_addr[ADDR_BIT_WIDTH-1:0]][8*b +: 8] <= req_wdata[8*b +: 8];
    end

`ifdef MMIO_TIMER_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            timer <= '0;
        else
            timer <= timer + 32'd1;
    end
`endif
endmodule

// File: tb/tb_mmio_memory_bus.sv
// tb_mmio_memory_bus: directed scenarios plus randomized traffic against a behavioural memory/MMIO model.
module tb_mmio_memory_bus;
    localparam logic [29:0] BASE = 30'h3FFFFFF0;

    logic        clk = 1'b0, reset = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [29:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
    logic [31:0] rsp_rdata;
    logic [3:0]  key_in = '0;
    logic [9:0]  sw_in = 10'h2A5;
    logic [15:0] hex_out;
    logic [9:0]  ledr_out;

    int checks = 0, fails = 0;
    logic [31:0] ram_m [16];
    logic [15:0] hex_m;
    logic [9:0]  ledr_m;

    mmio_memory_bus dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .key_in(key_in),
        .sw_in(sw_in), .hex_out(hex_out), .ledr_out(ledr_out)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic xact(input logic w, input logic [29:0] a, input logic [31:0] d, input logic [3:0] be,
                        output logic [31:0] rd, output logic er);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be; rsp_ready = 1'b1;
        checks++;
        if (req_ready !== 1'b1) begin fails++; $display("FAIL xact_ready: req_ready=%b required 1", req_ready); end
        step(1);
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1) begin fails++; $display("FAIL rsp_latency addr=%h: rsp_valid=%b required 1", a, rsp_valid); end
        rd = rsp_rdata;
        er = rsp_err;
        step(1);
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic er;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        checks++;
        if ({rsp_valid, rsp_rdata, rsp_err, hex_out, ledr_out} !== '0) begin
            fails++;
            $display("FAIL reset_state: valid=%b rdata=%h err=%b hex=%h ledr=%h required all 0", rsp_valid, rsp_rdata, rsp_err, hex_out, ledr_out);
        end
        checks++;
        if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: req_ready=%b required 1", req_ready); end
        req_valid = 1'b1; req_write = 1'b0; req_addr = 30'h10; rsp_ready = 1'b0;
        step(1);
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_drop: rsp_valid=%b required 0", rsp_valid); end
        step(1);
        reset = 1'b0;
        rsp_ready = 1'b1;
        step(1);
        xact(1'b1, BASE + 30'd4, 32'hF, 4'hF, rd, er);
        hex_m = '0; ledr_m = '0;
    endtask

    task automatic test_ram();
        logic [31:0] rd; logic er;
        xact(1'b1, 30'h10, 32'hDEADBEEF, 4'b1111, rd, er);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin fails++; $display("FAIL ram_write_rsp: rdata=%h err=%b required 0 0", rd, er); end
        xact(1'b0, 30'h10, 32'h0, 4'h0, rd, er);
        checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin fails++; $display("FAIL ram_read: rdata=%h err=%b required deadbeef 0", rd, er); end
        xact(1'b1, 30'h10, 32'h11223344, 4'b0101, rd, er);
        xact(1'b0, 30'h10, 32'h0, 4'h0, rd, er);
        checks++;
        if (rd !== 32'hDE22BE44) begin fails++; $display("FAIL ram_be: rdata=%h required de22be44", rd); end
        xact(1'b1, 30'h10, 32'hFFFFFFFF, 4'b0000, rd, er);
        xact(1'b1, 30'h11, 32'hCAFEF00D, 4'b1111, rd, er);
        xact(1'b0, 30'h10, 32'h0, 4'h0, rd, er);
        checks++;
        if (rd !== 32'hDE22BE44) begin fails++; $display("FAIL ram_be_zero: rdata=%h required de22be44", rd); end
    endtask

    task automatic test_back_to_back();
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 30'h10;
        step(1);
        req_addr = 30'h11;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'hDE22BE44) begin
                fails++;
                $display("FAIL stall: ready=%b valid=%b rdata=%h required 0 1 de22be44", req_ready, rsp_valid, rsp_rdata);
            end
            step(1);
        end
        rsp_ready = 1'b1;
        #1;
        step(1);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFEF00D) begin fails++; $display("FAIL b2b_first: valid=%b rdata=%h required 1 cafef00d", rsp_valid, rsp_rdata); end
        req_addr = 30'h10;
        step(1);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDE22BE44) begin fails++; $display("FAIL b2b_second: valid=%b rdata=%h required 1 de22be44", rsp_valid, rsp_rdata); end
        req_valid = 1'b0;
        step(1);
        checks++;
        if (rsp_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain: rsp_valid=%b required 0", rsp_valid); end
    endtask

    task automatic test_mmio();
        logic [31:0] rd; logic er;
        xact(1'b1, BASE + 30'd1, 32'h3FF, 4'h0, rd, er);
        checks++;
        if (ledr_out !== 10'h3FF) begin fails++; $display("FAIL ledr_write: ledr_out=%h required 3ff", ledr_out); end
        xact(1'b1, BASE, 32'h1ABCD, 4'h0, rd, er);
        checks++;
        if (hex_out !== 16'hABCD) begin fails++; $display("FAIL hex_write: hex_out=%h required abcd", hex_out); end
        hex_m = 16'hABCD; ledr_m = 10'h3FF;
        xact(1'b0, BASE, 32'h0, 4'h0, rd, er);
        checks++;
        if (rd !== 32'h0000ABCD || er !== 1'b0) begin fails++; $display("FAIL hex_read: rdata=%h err=%b required 0000abcd 0", rd, er); end
        xact(1'b0, BASE + 30'd9, 32'h0, 4'h0, rd, er);
        checks++;
        if (rd !== 32'h0 || er !== 1'b1) begin fails++; $display("FAIL unmapped: rdata=%h err=%b required 0 1", rd, er); end
        xact(1'b1, BASE + 30'd3, 32'h1, 4'hF, rd, er);
        checks++;
        if (er !== 1'b0) begin fails++; $display("FAIL sw_write_err: err=%b required 0", er); end
        xact(1'b0, BASE + 30'd3, 32'h0, 4'h0, rd, er);
        checks++;
        if (rd !== {22'h0, sw_in}) begin fails++; $display("FAIL sw_read: rdata=%h required %h", rd, sw_in); end
    endtask

    task automatic test_keys();
        logic [31:0] rd; logic er;
        key_in = 4'b0100;
        step(3);
        xact(1'b0, BASE + 30'd2, 32'h0, 4'h0, rd, er);
        checks++;
        if (rd !== 32'h4) begin fails++; $display("FAIL key_level: rdata=%h required 4", rd); end
        key_in = 4'b0000;
        step(3);
        xact(1'b0, BASE + 30'd4, 32'h0, 4'h0, rd, er);
        checks++;
        if (rd !== 32'h4) begin fails++; $display("FAIL keyp_sticky: rdata=%h required 4", rd); end
        xact(1'b1, BASE + 30'd4, 32'h4, 4'h0, rd, er);
        xact(1'b0, BASE + 30'd4, 32'h0, 4'h0, rd, er);
        checks++;
        if (rd !== 32'h0) begin fails++; $display("FAIL keyp_clear: rdata=%h required 0", rd); end
        key_in = 4'b0100;
        step(2);
        xact(1'b1, BASE + 30'd4, 32'h4, 4'h0, rd, er);
        xact(1'b0, BASE + 30'd4, 32'h0, 4'h0, rd, er);
        checks++;
        if (rd !== 32'h4) begin fails++; $display("FAIL keyp_set_wins: rdata=%h required 4", rd); end
        key_in = 4'b0000;
        step(3);
        xact(1'b1, BASE + 30'd4, 32'hF, 4'h0, rd, er);
        xact(1'b0, BASE + 30'd4, 32'h0, 4'h0, rd, er);
        checks++;
        if (rd !== 32'h0) begin fails++; $display("FAIL keyp_final_clear: rdata=%h required 0", rd); end
    endtask

    task automatic test_timer();
        logic [31:0] t0, t1; logic e0, e1;
        int n;
        n = $urandom_range(3, 20);
        xact(1'b0, BASE + 30'd5, 32'h0, 4'h0, t0, e0);
        step(n);
        xact(1'b0, BASE + 30'd5, 32'h0, 4'h0, t1, e1);
`ifdef MMIO_TIMER_EN
        checks++;
        if (t1 - t0 !== 32'(n + 2) || e0 !== 1'b0) begin fails++; $display("FAIL timer_delta: delta=%0d err=%b required %0d 0", t1 - t0, e0, n + 2); end
`else
        checks++;
        if (e0 !== 1'b1 || e1 !== 1'b1 || t0 !== 32'h0) begin fails++; $display("FAIL timer_absent: err=%b rdata=%h required 1 0", e0, t0); end
`endif
    endtask

    task automatic test_random();
        logic [31:0] rd, d, exp_rd; logic er, exp_er, w;
        logic [29:0] a, o;
        logic [3:0] be;
        int kind;
        for (int i = 0; i < 16; i++) begin
            ram_m[i] = $urandom;
            xact(1'b1, 30'(i), ram_m[i], 4'hF, rd, er);
        end
        for (int it = 0; it < 300; it++) begin
            kind = $urandom_range(0, 9);
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            be = 4'($urandom_range(0, 15));
            o = kind == 6 ? 30'd0 : kind == 7 ? 30'd1 : kind == 8 ? 30'($urandom_range(2, 4)) : 30'($urandom_range(6, 15));
            a = kind < 6 ? 30'($urandom_range(0, 15)) : (kind == 9 && $urandom_range(0, 1) == 1) ? 30'h1000 + 30'($urandom_range(0, 255)) : BASE + o;
            exp_er = kind == 9;
            exp_rd = w ? 32'h0 : kind < 6 ? ram_m[a[3:0]] : o == 30'd0 ? {16'h0, hex_m} : o == 30'd1 ? {22'h0, ledr_m} :
                     o == 30'd3 ? {22'h0, sw_in} : 32'h0;
            if (kind == 9) exp_rd = 32'h0;
            xact(w, a, d, be, rd, er);
            if (w && kind < 6)
                for (int b = 0; b < 4; b++)
                    if (be[b]) ram_m[a[3:0]][8*b +: 8] = d[8*b +: 8];
            if (w && kind == 6) hex_m = d[15:0];
            if (w && kind == 7) ledr_m = d[9:0];
            checks++;
            if (rd !== exp_rd || er !== exp_er) begin
                fails++;
                $display("FAIL random[%0d] addr=%h w=%b: rdata=%h err=%b required %h %b", it, a, w, rd, er, exp_rd, exp_er);
            end
            checks++;
            if (hex_out !== hex_m || ledr_out !== ledr_m) begin
                fails++;
                $display("FAIL random_regs[%0d]: hex=%h ledr=%h required %h %h", it, hex_out, ledr_out, hex_m, ledr_m);
            end
            step($urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_back_to_back();
        test_mmio();
        test_keys();
        test_timer();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
